// File: rtl/imem_loader_fetch.sv
// Instruction-memory loader (DIP + debounced keys) and sequential fetch unit.
// Build option FETCH_HALT_ON_ZERO_EN: a fetched zero word halts the fetch stream.
module imem_loader_fetch #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dip,
  input  logic [4:0]        key,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              run,
  output logic [DATA_W-1:0] led
);

  typedef enum logic [2:0] {
    LOAD_IDLE,
    LOAD_WR,
    RUN_REQ,
    RUN_WAIT,
    RUN_HOLD
`ifdef FETCH_HALT_ON_ZERO_EN
    , HALTED
`endif
  } state_t;

  logic unused_keys;
  assign unused_keys = ^key[4:3];

  logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]  deb_q, deb_d, pulse_q, pulse_d;
  logic [19:0] cnt_q [3];
  logic [19:0] cnt_d [3];

  always_comb begin
    sync1_d = key[2:0];
    sync2_d = sync1_q;
    for (int unsigned i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      // Level changes only after DEBOUNCE_CYC consecutive samples differ from it.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYC - 20'd1) deb_d[i] = sync2_q[i];
        else                                  cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
    pulse_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic commit_p, mode_p, clr_p;
  assign commit_p = pulse_q[0];
  assign mode_p   = pulse_q[1];
  assign clr_p    = pulse_q[2];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, instr_q, instr_d, led_q, led_d;
  logic              we_q, we_d, valid_q, valid_d, run_q, run_d;
  logic              in_run;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    instr_d = instr_q;
    valid_d = valid_q;
    run_d   = run_q;
    in_run  = (state_q != LOAD_IDLE) && (state_q != LOAD_WR);
    case (state_q)
      LOAD_IDLE: begin
        if (clr_p) begin
          addr_d = '0;
        end else if (mode_p) begin
          addr_d  = '0;
          run_d   = 1'b1;
          state_d = RUN_REQ;
        end else if (commit_p) begin
          din_d   = dip;
          we_d    = 1'b1;
          state_d = LOAD_WR;
        end
      end
      LOAD_WR: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = LOAD_IDLE;
      end
      RUN_REQ:  state_d = RUN_WAIT;
      RUN_WAIT: begin
`ifdef FETCH_HALT_ON_ZERO_EN
        if (mem_dout == '0) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else
`endif
        begin
          instr_d = mem_dout;
          valid_d = 1'b1;
          state_d = RUN_HOLD;
        end
      end
      RUN_HOLD: begin
        if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RUN_REQ;
        end
      end
`ifdef FETCH_HALT_ON_ZERO_EN
      HALTED: state_d = HALTED;
`endif
      default: state_d = LOAD_IDLE;
    endcase

    // Key pulses in RUN override whatever the fetch sequence decided this cycle.
    if (in_run) begin
      if (clr_p) begin
        valid_d = 1'b0;
        addr_d  = '0;
        state_d = RUN_REQ;
      end else if (mode_p) begin
        valid_d = 1'b0;
        run_d   = 1'b0;
        addr_d  = '0;
        state_d = LOAD_IDLE;
      end
    end

    if (run_d) led_d = instr_d;
    else       led_d = DATA_W'({addr_d, dip[7:0]});
`ifdef FETCH_HALT_ON_ZERO_EN
    if (state_d == HALTED) led_d = DATA_W'(16'hDEAD);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      run_q   <= run_d;
      led_q   <= led_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_din     = din_q;
  assign mem_we      = we_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign run         = run_q;
  assign led         = led_q;

endmodule

// File: doc/imem_loader_fetch.md
Name: imem_loader_fetch

Overview:
- Sits directly upstream of the 16x256 single-port instruction memory (addr/din/we/dout, 1-cycle synchronous read).
- LOAD mode: operator enters program words on the DIP switches and commits each with a debounced key press.
- RUN mode: block drives sequential reads and streams fetched words to the downstream decoder over a valid/ready handshake.
- Sole owner of the memory address, write-enable and write-data nets.

Parameters:
ADDR_W, 8, memory address width (depth 2^ADDR_W)
DATA_W, 16, instruction / DIP width
DEBOUNCE_CYC, 20'd500000, stable cycles a key must hold before it is accepted (bench overrides to 4)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
dip  in  DATA_W  DIP switch word to be written
key  in  5  raw push buttons: [0] commit/step, [1] mode toggle, [2] address clear, [4:3] unused
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_dout  in  DATA_W  memory read data, valid 1 cycle after mem_addr
instr  out  DATA_W  fetched instruction
instr_valid  out  1  instr holds a valid word
instr_ready  in  1  downstream accepts instr
run  out  1  1 = RUN mode, 0 = LOAD mode
led  out  DATA_W  status display

Behaviour:
- Clock/reset (decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: mem_addr=0, mem_din=0, mem_we=0, instr=0, instr_valid=0, run=0, led=0, FSM=LOAD_IDLE, debounce counters=0.
- Key conditioning, per key[2:0]:
  - 2-flop synchronizer, then a counter that requires DEBOUNCE_CYC consecutive equal samples.
  - Rising edge of the debounced level gives a 1-cycle pulse (commit_p, mode_p, clr_p).
  - Key held: exactly one pulse.
- Pulse priority when simultaneous: clr_p > mode_p > commit_p; lower-priority pulses that cycle are dropped.
- FSM states: LOAD_IDLE, LOAD_WR, RUN_REQ, RUN_WAIT, RUN_HOLD.
- LOAD_IDLE:
  - commit_p: mem_din<=dip, mem_we<=1, go LOAD_WR.
  - clr_p: mem_addr<=0.
  - mode_p: mem_addr<=0, run<=1, go RUN_REQ.
- LOAD_WR: mem_we<=0, mem_addr<=mem_addr+1 (wraps 255->0), return LOAD_IDLE. Write pulse is exactly 1 cycle.
- RUN_REQ: mem_addr is stable; go RUN_WAIT (address presented; read latency 1).
- RUN_WAIT: instr<=mem_dout, instr_valid<=1, go RUN_HOLD.
- RUN_HOLD:
  - instr and instr_valid stay stable until instr_ready=1.
  - On handshake (instr_valid & instr_ready): instr_valid<=0, mem_addr<=mem_addr+1 (wrap to 0), go RUN_REQ.
  - Throughput: one word per 3 cycles, ready held high.
- RUN-mode pulses:
  - mode_p in any RUN_* state: instr_valid<=0, run<=0, mem_addr<=0, go LOAD_IDLE. In-flight word discarded.
  - clr_p in RUN_*: instr_valid<=0, mem_addr<=0, go RUN_REQ (restart program).
  - commit_p ignored in RUN.
- mem_we is never 1 while run=1.
- led: LOAD shows {mem_addr, dip[7:0]}; RUN shows instr.
- Mid-operation reset: all state returns to reset values asynchronously. A write in progress is abandoned; mem_we deasserts immediately.

Optional Feature:
FETCH_HALT_ON_ZERO_EN
- Defined:
  - A fetched word equal to 0 is treated as HALT.
  - RUN_WAIT with mem_dout==0 enters HALTED: instr_valid=0, mem_addr frozen, led=16'hDEAD.
  - Only mode_p (to LOAD_IDLE) or clr_p (to RUN_REQ, addr 0) leaves HALTED.
- Undefined: zero words are streamed like any other; no HALTED state exists.

Test Plan:
- Async reset mid-LOAD_WR (rst_n low between clock edges) -> mem_we=0 and mem_addr=0 before the next clk edge; all outputs at reset values.
- LOAD: dip=16'h1234 then commit; dip=16'hABCD then commit (DEBOUNCE_CYC=4) -> two 1-cycle mem_we pulses at addr 0 and 1 with matching din; mem_addr ends at 2.
- Key bounce: key[0] toggled for 3 cycles, then held 10 cycles -> exactly one write.
- RUN with instr_ready tied 1 after loading 1234/ABCD -> instr 16'h1234 then 16'hABCD; instr_valid pulses every 3rd cycle; mem_addr 0,1,2.
- Backpressure: instr_ready=0 for 7 cycles -> instr/instr_valid stable, mem_addr unchanged; ready=1 -> advance.
- Boundary/priority:
  - mem_addr=255 commit -> addr wraps to 0.
  - mode and clr pressed in the same cycle in RUN -> clr wins, run stays 1, restart at addr 0.
  - With FETCH_HALT_ON_ZERO_EN, word 0 at addr 2 -> HALTED, led=16'hDEAD, addr frozen at 2.
